// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM march self-test sequencer.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD0,
    S_WR1,
    S_RD1,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] PH_WR0 = 2'd0;
  localparam logic [1:0] PH_RD0 = 2'd1;
  localparam logic [1:0] PH_WR1 = 2'd2;
  localparam logic [1:0] PH_RD1 = 2'd3;

  localparam int unsigned         ERR_W   = 8;
  localparam logic [ERR_W-1:0]    ERR_MAX = 8'd255;

endpackage

// File: rtl/sram_bist_if.sv
// Request/response port between the BIST sequencer and the sramtest wrapper.
interface sram_bist_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2
);
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;

  modport master (output we, wmask, addr, din, input dout);
  modport slave  (input we, wmask, addr, din, output dout);
endinterface

// File: rtl/sram_bist_cmp_pipe.sv
// Read-expectation delay line; compares the emerging entry against SRAM dout.
module bist_cmp_pipe #(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] mismatch_addr
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   exp_q  [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   addr_q [READ_LATENCY];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= push;
      exp_q[0]  <= expected;
      addr_q[0] <= addr;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        exp_q[i]  <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  always_comb begin
    mismatch      = vld_q[READ_LATENCY-1] && (dout != exp_q[READ_LATENCY-1]);
    mismatch_addr = addr_q[READ_LATENCY-1];
  end

endmodule

// File: rtl/sram_bist.sv
// Four-phase write/read-back march over the full SRAM address range.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 6,
  parameter int WMASK_WIDTH  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  sram_bist_if.master           sram
);

  localparam int unsigned DCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DCW-1:0]        DRAIN_LAST = DCW'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

  state_t                 state_q, nxt;
  logic [1:0]             phase_q, phase_n;
  logic [DCW-1:0]         drain_q, drain_n;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
  logic [DATA_WIDTH-1:0]  pat_q, pat_n;
  logic [DATA_WIDTH-1:0]  din_q, din_n;
  logic [WMASK_WIDTH-1:0] mask_q, mask_n;
  logic                   we_q, we_n;
  logic                   busy_q, busy_n, done_q, done_n, pass_q, pass_n;
  logic [ERR_W-1:0]       err_q, err_n;
  logic [ADDR_WIDTH-1:0]  fail_q, fail_n;
  logic                   first_q, first_n;
  logic                   accept, push;
  logic [DATA_WIDTH-1:0]  exp_n;
  logic                   mismatch;
  logic [ADDR_WIDTH-1:0]  mismatch_addr;

  bist_cmp_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_cmp (
    .clock         (clock),
    .reset         (reset),
    .push          (push),
    .expected      (exp_n),
    .addr          (addr_n),
    .dout          (sram.dout),
    .mismatch      (mismatch),
    .mismatch_addr (mismatch_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_WR0;
      drain_q <= '0;
      addr_q  <= '0;
      pat_q   <= '0;
      din_q   <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= nxt;
      phase_q <= phase_n;
      drain_q <= drain_n;
      addr_q  <= addr_n;
      pat_q   <= pat_n;
      din_q   <= din_n;
      mask_q  <= mask_n;
      we_q    <= we_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      fail_q  <= fail_n;
      first_q <= first_n;
    end
  end

  // Request outputs are decoded from the next state so they leave as registers
  // on the same edge the state advances.
  always_comb begin
    nxt     = state_q;
    phase_n = phase_q;
    drain_n = drain_q;
    addr_n  = addr_q;
    pat_n   = pat_q;
    accept  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          nxt     = S_WR0;
          phase_n = PH_WR0;
          addr_n  = '0;
          pat_n   = pattern;
        end
      end
      S_WR0, S_RD0: begin
        if (addr_q == ADDR_LAST) begin
          nxt     = S_DRAIN;
          drain_n = '0;
        end else begin
          addr_n = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_WR1, S_RD1: begin
        if (addr_q == '0) begin
          nxt     = S_DRAIN;
          drain_n = '0;
        end else begin
          addr_n = addr_q - ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          case (phase_q)
            PH_WR0:  begin nxt = S_RD0; phase_n = PH_RD0; addr_n = '0;        end
            PH_RD0:  begin nxt = S_WR1; phase_n = PH_WR1; addr_n = ADDR_LAST; end
            PH_WR1:  begin nxt = S_RD1; phase_n = PH_RD1; addr_n = ADDR_LAST; end
            default: begin nxt = S_DONE;                  addr_n = '0;        end
          endcase
        end else begin
          drain_n = drain_q + DCW'(1);
        end
      end
      default: nxt = S_IDLE;
    endcase

    we_n   = (nxt == S_WR0) || (nxt == S_WR1);
    din_n  = (nxt == S_WR0) ? pat_n : ((nxt == S_WR1) ? ~pat_n : '0);
    mask_n = we_n ? '1 : '0;
    push   = (nxt == S_RD0) || (nxt == S_RD1);
    exp_n  = (nxt == S_RD1) ? ~pat_n : pat_n;
    busy_n = !((nxt == S_IDLE) || (nxt == S_DONE));
    done_n = (nxt == S_DONE);

    err_n   = err_q;
    fail_n  = fail_q;
    first_n = first_q;
    if (mismatch) begin
      if (err_q != ERR_MAX) err_n = err_q + ERR_W'(1);
      if (!first_q) begin
        first_n = 1'b1;
        fail_n  = mismatch_addr;
      end
    end
    if (accept) begin
      err_n   = '0;
      fail_n  = '0;
      first_n = 1'b0;
    end
    pass_n = done_n && (err_n == '0);
  end

  assign sram.we    = we_q;
  assign sram.wmask = mask_q;
  assign sram.addr  = addr_q;
  assign sram.din   = din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_addr  = fail_q;

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench: behavioural SRAM models with fault hooks around two sram_bist instances.
module tb_sram_bist;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pattern = 4'h0;
  logic       start2 = 1'b0;

  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [5:0] fail_addr;
  logic       busy2, done2, pass2;
  logic [7:0] err_count2;
  logic [7:0] fail_addr2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;
  int wr_cnt = 0;
  int mask_bad = 0;
  logic fault_en = 1'b0;

  logic [3:0] mem1 [64];
  logic [3:0] mem2 [256];
  logic [3:0] rd1;

  sram_bist_if #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) sif ();
  sram_bist_if #(.DATA_WIDTH(4), .ADDR_WIDTH(8), .WMASK_WIDTH(2)) sif2 ();

  sram_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2), .READ_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .sram(sif)
  );

  sram_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(8), .WMASK_WIDTH(2), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .pattern(pattern),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_addr(fail_addr2), .sram(sif2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    sif.dout  = 4'h0;
    sif2.dout = 4'h0;
  end

  // Request sampled at t+1, data registered out: valid for the compare at t+2.
  always @(posedge clock) begin
    if (sif.we) begin
      mem1[sif.addr] <= sif.din;
      wr_cnt = wr_cnt + 1;
      if (sif.wmask != 2'b11) mask_bad = mask_bad + 1;
    end else begin
      rd1 = mem1[sif.addr];
      if (fault_en && sif.addr == 6'd5) rd1[0] = 1'b0;
      sif.dout <= rd1;
    end
  end

  always @(posedge clock) begin
    if (sif2.we) mem2[sif2.addr] <= sif2.din;
    else         sif2.dout <= ~mem2[sif2.addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [3:0] p);
    @(negedge clock);
    start   = 1'b1;
    pattern = p;
    @(posedge clock);
    #1;
    e0     = cyc;
    start  = 1'b0;
    wr_cnt = 0;
    mask_bad = 0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int bound, input int lat);
    int n = 0;
    while (!done && n < bound) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cyc - e0, lat);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_we"}, sif.we, 0);
    check({tag, "_wmask"}, sif.wmask, 0);
    check({tag, "_addr"}, sif.addr, 0);
    check({tag, "_din"}, sif.din, 0);
  endtask

  initial begin
    int bad;
    int n;

    // 1. asynchronous reset with no clock edge
    #1 reset = 1'b1;
    #1 check_idle_outputs("rst");
    check("rst2_busy", busy2, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_busy", busy, 0);
    check("idle_addr", sif.addr, 0);

    // 2. clean run, P=D
    start_run(4'hD);
    check("e0_we", sif.we, 1);
    check("e0_addr", sif.addr, 0);
    check("e0_din", sif.din, 4'hD);
    check("e0_wmask", sif.wmask, 2'b11);
    check("e0_busy", busy, 1);
    wait_to(e0 + 64);
    check("drain0_we", sif.we, 0);
    check("drain0_addr", sif.addr, 63);
    wait_to(e0 + 65);
    check("drain0b_addr", sif.addr, 63);
    wait_to(e0 + 66);
    check("rd0_we", sif.we, 0);
    check("rd0_addr", sif.addr, 0);
    wait_to(e0 + 132);
    check("wr1_we", sif.we, 1);
    check("wr1_addr", sif.addr, 63);
    check("wr1_din", sif.din, 4'h2);
    wait_to(e0 + 198);
    check("rd1_addr", sif.addr, 63);
    wait_done("clean", 400, 264);
    check("clean_pass", pass, 1);
    check("clean_err", err_count, 0);
    check("clean_busy", busy, 0);
    check("clean_addr", sif.addr, 0);
    check("clean_writes", wr_cnt, 128);
    check("clean_wmask_bad", mask_bad, 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem1[i] !== 4'h2) bad++;
    check("clean_mem_inv", bad, 0);

    // 3. stuck-at-0 on bit 0 of address 5
    fault_en = 1'b1;
    start_run(4'hD);
    wait_done("fault", 400, 264);
    check("fault_err", err_count, 1);
    check("fault_addr", fail_addr, 5);
    check("fault_pass", pass, 0);

    // 4b. start in DONE clears results and repeats
    fault_en = 1'b0;
    start_run(4'hD);
    check("restart_done", done, 0);
    check("restart_err", err_count, 0);
    check("restart_fail_addr", fail_addr, 0);
    check("restart_busy", busy, 1);
    // 4a. start mid-RD0 with another pattern is ignored
    wait_to(e0 + 80);
    @(negedge clock);
    start   = 1'b1;
    pattern = 4'h6;
    @(posedge clock); #1;
    start = 1'b0;
    check("ign_busy", busy, 1);
    check("ign_addr", sif.addr, 15);
    wait_done("ignore", 400, 264);
    check("ignore_pass", pass, 1);
    check("ignore_err", err_count, 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem1[i] !== 4'h2) bad++;
    check("ignore_mem_inv", bad, 0);

    // 5. reset mid-run
    fault_en = 1'b1;
    start_run(4'hD);
    wait_to(e0 + 100);
    check("pre_rst_err", err_count, 1);
    #2 reset = 1'b1;
    #1 check_idle_outputs("midrst");
    @(negedge clock);
    reset = 1'b0;
    fault_en = 1'b0;
    start_run(4'hD);
    wait_done("postrst", 400, 264);
    check("postrst_pass", pass, 1);
    check("postrst_err", err_count, 0);

    // 6. saturation on the 256-word instance with an inverting model
    @(negedge clock);
    start2 = 1'b1;
    @(posedge clock); #1;
    e0 = cyc;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("sat_done_seen", done2, 1);
    check("sat_latency", cyc - e0, 1032);
    check("sat_err", err_count2, 255);
    check("sat_fail_addr", fail_addr2, 0);
    check("sat_pass", pass2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
